seq_mult_nxn: RTL and testbench
===============================

# seq_mult_nxn

Parametrised sequential W×W multiplier built around the existing combinational `mult4x4` core. It splits each operand into 4-bit digits and accumulates one shifted 4×4 partial product per clock, so a full product takes (W/4)² cycles. A start/done handshake frames each operation, and the result is held in a registered product output. It is the width-generic successor to the fixed 8×8 sequential multiplier and feeds the same downstream product/display path.

## Interface
- `W`, default 8: operand width. Must be a multiple of 4 and ≥ 4. K = (W/4)² partial-product cycles.
- `clk` in 1: single clock, rising edge.
- `reset_a` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation. Sampled only in IDLE.
- `dataa` in W: multiplicand. Latched on the accepted start edge.
- `datab` in W: multiplier. Latched on the accepted start edge.
- `signed_mode` in 1: present only with `SEQ_MULT_SIGNED_EN`. 1 selects two's-complement operands. Latched with the operands.
- `busy` out 1: high while an operation is in progress.
- `done_flag` out 1: one-cycle pulse when `product` is updated.
- `product` out 2W: registered result, held until the next completion or reset.

## Operation
- FSM states:
  - IDLE: default after reset.
  - CALC: runs K cycles.
  - FIN: runs 1 cycle, then returns to IDLE.
- IDLE:
  - If `start`=1 at an edge, latch operands, clear the accumulator and digit counter, and go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Counter c = 0..K-1 selects a-digit i = c mod (W/4) and b-digit j = c div (W/4).
  - Each cycle: acc += mult4x4(a[4i+3:4i], b[4j+3:4j]) << 4(i+j).
  - When c = K-1, go to FIN.
- Accumulator width is 2W. No intermediate overflow is possible; the final sum is < 2^(2W).
- FIN: write `product` <= acc, set `done_flag`=1, go to IDLE.
- `start` while busy (CALC or FIN) is ignored. No queuing.
- Operand changes after the accepted start have no effect on the current operation.
- Reset (`reset_a`=0), including mid-operation:
  - State goes to IDLE immediately; acc and counter clear.
  - Outputs: `busy`=0, `done_flag`=0, `product`=0.
  - An aborted operation never produces `done_flag`.

## Timing
- Start accepted at edge E.
- `busy`=1 from edge E until edge E+K+1, where it deasserts.
- `product` is valid and `done_flag`=1 for exactly one cycle, both set at edge E+K+1. Latency = K+1 cycles.
  - W=4: 2 cycles.
  - W=8: 5 cycles.
  - W=16: 17 cycles.
- Back-to-back operation: if `start`=1 during the `done_flag` cycle (state IDLE), it is accepted at that edge. `done_flag` clears and `busy` re-asserts on the same edge.
- `done_flag` is never high for two consecutive cycles.

## Configuration
- `SEQ_MULT_SIGNED_EN` defined:
  - Adds the `signed_mode` port.
  - With `signed_mode`=1:
    - Operands are converted to magnitudes at latch time.
    - The result sign is the XOR of the operand MSBs.
    - FIN writes the two's-complement of acc when the sign is negative.
    - Latency is unchanged.
    - The most-negative operand (-2^(W-1)) has magnitude 2^(W-1), which still fits unsigned in W bits.
  - With `signed_mode`=0: behaviour is identical to the undefined case.
- `SEQ_MULT_SIGNED_EN` undefined: no `signed_mode` port; unsigned operation only.

## Test plan
- W=8, `dataa`=0xA5, `datab`=0x3C, `start` at E → `product`=0x26AC and `done_flag`=1 at E+5; `busy` high during cycles E..E+4.
- W=8, 0xFF×0xFF, then `start` again during the `done_flag` cycle with 0x00×0x7B:
  - First result `product`=0xFE01.
  - Second result `product`=0x0000 exactly 5 cycles later.
  - No idle gap between the two operations.
- W=8: pulse `start` at E+2 while busy, and change `dataa` at E+1 → result still uses the original operands; only one `done_flag`.
- Assert `reset_a`=0 at E+3 → outputs are 0 asynchronously with no `done_flag`. A new start after release → correct result 5 cycles later.
- W=16, 0xFFFF×0xFFFF → `product`=0xFFFE0001 with `done_flag` at E+17.
- `SEQ_MULT_SIGNED_EN`, W=8, `signed_mode`=1:
  - 0xFD×0x07 → 0xFFEB.
  - 0x80×0x80 → 0x4000.
  - 0x80×0x01 → 0xFF80.
  - `signed_mode`=0 with 0xFD×0x07 → 0x06EB.

Source files
------------

// File: rtl/seq_mult_nxn.sv
// Sequential WxW multiplier: accumulates one shifted 4x4 digit product per clock, (W/4)^2 cycles per operation.
// Optional two's-complement operand support is enabled by defining SEQ_MULT_SIGNED_EN.

module mult4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0000, a} * {4'b0000, b};

endmodule

module seq_mult_nxn #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset_a,
  input  logic           start,
  input  logic [W-1:0]   dataa,
  input  logic [W-1:0]   datab,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic           signed_mode,
`endif
  output logic           busy,
  output logic           done_flag,
  output logic [2*W-1:0] product
);

  localparam int D  = W / 4;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * W;
  localparam logic [DW-1:0] LAST = DW'(D - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [PW-1:0] acc;
  logic [DW-1:0] i_idx;
  logic [DW-1:0] j_idx;
  logic          neg;

  logic          sign_sel;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [7:0]    pp;
  logic [DW:0]   pos;
  logic [PW-1:0] pp_shift;

`ifdef SEQ_MULT_SIGNED_EN
  assign sign_sel = signed_mode;
`else
  assign sign_sel = 1'b0;
`endif

  // Signed operands are reduced to magnitudes at latch time; -2^(W-1) still fits unsigned.
  always_comb begin
    a_mag = dataa;
    b_mag = datab;
    if (sign_sel && dataa[W-1]) a_mag = (~dataa) + W'(1);
    if (sign_sel && datab[W-1]) b_mag = (~datab) + W'(1);
  end

  always_comb begin
    a_dig    = a_reg[{i_idx, 2'b00} +: 4];
    b_dig    = b_reg[{j_idx, 2'b00} +: 4];
    pos      = {1'b0, i_idx} + {1'b0, j_idx};
    pp_shift = PW'(pp) << {pos, 2'b00};
  end

  mult4x4 u_core (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  // i walks the a-digits fastest; the last (i, j) pair hands over to FIN.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
      neg       <= 1'b0;
      busy      <= 1'b0;
      done_flag <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_flag <= 1'b0;
          if (start) begin
            a_reg <= a_mag;
            b_reg <= b_mag;
            neg   <= sign_sel & (dataa[W-1] ^ datab[W-1]);
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc + pp_shift;
          if (i_idx == LAST) begin
            i_idx <= '0;
            if (j_idx == LAST) begin
              state <= FIN;
            end else begin
              j_idx <= j_idx + DW'(1);
            end
          end else begin
            i_idx <= i_idx + DW'(1);
          end
        end
        FIN: begin
          product   <= neg ? ((~acc) + PW'(1)) : acc;
          done_flag <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_nxn.sv
// Scoreboard bench for seq_mult_nxn: W=8 instance for protocol scenarios, W=16 instance for the wide case.
// Signed scenarios are included when SEQ_MULT_SIGNED_EN is defined.

module tb_seq_mult_nxn;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic        signed_mode;
  logic        busy;
  logic        done_flag;
  logic [15:0] product;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        signed_mode16;
  logic        busy16;
  logic        done16;
  logic [31:0] product16;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  logic [31:0] exp16_q[$];

  always #5 clk = ~clk;

  seq_mult_nxn #(.W(8)) dut8 (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start),
    .dataa       (dataa),
    .datab       (datab),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done_flag   (done_flag),
    .product     (product)
  );

  seq_mult_nxn #(.W(16)) dut16 (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start16),
    .dataa       (a16),
    .datab       (b16),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode (signed_mode16),
`endif
    .busy        (busy16),
    .done_flag   (done16),
    .product     (product16)
  );

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [15:0] sp;
    if (sm) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      sp = sa * sb;
      return sp;
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  task automatic issue_op(input logic [7:0] a, input logic [7:0] b, input logic sm, input bit track);
    dataa       = a;
    datab       = b;
    signed_mode = sm;
    start       = 1'b1;
    if (track) exp_q.push_back(model8(a, b, sm));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; cyc ends as K+1 when done_flag appears on time.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (done_flag !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b0;
    start = 1'b0; dataa = '0; datab = '0; signed_mode = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; signed_mode16 = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++;
    if (done_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done_flag); end
    vectors++;
    if (product !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_product: got %h expected 0000", product); end
    vectors++;
    if (busy16 !== 1'b0 || product16 !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_w16: got busy=%b product=%h expected 0/00000000", busy16, product16);
    end
    reset_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] av[4];
    logic [7:0] bv[4];
    logic [15:0] exp;
    int cyc;
    bit ok;
    av[0] = 8'hA5; bv[0] = 8'h3C;
    av[1] = 8'h01; bv[1] = 8'hFF;
    for (int k = 2; k < 4; k++) begin
      av[k] = 8'($urandom_range(0, 255));
      bv[k] = 8'($urandom_range(0, 255));
    end
    for (int k = 0; k < 4; k++) begin
      issue_op(av[k], bv[k], 1'b0, 1'b1);
      wait_done(cyc, ok);
      exp = exp_q.pop_front();
      vectors++;
      if (cyc != 5) begin miscompares++; $display("[TB] FAIL basic_latency[%0d]: got %0d expected 5", k, cyc); end
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL basic_busy[%0d]: got busy low expected high during calc", k); end
      vectors++;
      if (product !== exp) begin miscompares++; $display("[TB] FAIL basic_product[%0d]: got %h expected %h", k, product, exp); end
      @(negedge clk);
      vectors++;
      if (done_flag !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("[TB] FAIL basic_pulse[%0d]: got done=%b busy=%b expected 0/0", k, done_flag, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int cyc;
    bit ok;
    issue_op(8'hFF, 8'hFF, 1'b0, 1'b1);
    wait_done(cyc, ok);
    exp = exp_q.pop_front();
    vectors++;
    if (product !== exp) begin miscompares++; $display("[TB] FAIL b2b_first: got %h expected %h", product, exp); end
    issue_op(8'h00, 8'h7B, 1'b0, 1'b1);
    vectors++;
    if (busy !== 1'b1 || done_flag !== 1'b0) begin
      miscompares++; $display("[TB] FAIL b2b_gap: got busy=%b done=%b expected 1/0", busy, done_flag);
    end
    wait_done(cyc, ok);
    exp = exp_q.pop_front();
    vectors++;
    if (cyc != 5 || !ok) begin miscompares++; $display("[TB] FAIL b2b_latency: got %0d busy_ok=%b expected 5/1", cyc, ok); end
    vectors++;
    if (product !== exp) begin miscompares++; $display("[TB] FAIL b2b_second: got %h expected %h", product, exp); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    logic [15:0] exp;
    logic [15:0] seen;
    int pulses;
    issue_op(8'h5A, 8'hC3, 1'b0, 1'b1);
    dataa = 8'h11;
    @(negedge clk);
    start = 1'b1; dataa = 8'h33; datab = 8'h22;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    seen = '0;
    for (int n = 0; n < 15; n++) begin
      if (done_flag === 1'b1) begin
        if (pulses == 0) seen = product;
        pulses++;
      end
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (pulses != 1) begin miscompares++; $display("[TB] FAIL ignore_pulses: got %0d expected 1", pulses); end
    vectors++;
    if (seen !== exp) begin miscompares++; $display("[TB] FAIL ignore_product: got %h expected %h", seen, exp); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] exp;
    int cyc;
    int pulses;
    bit ok;
    issue_op(8'h37, 8'h59, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset_a = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done_flag !== 1'b0 || product !== 16'h0) begin
      miscompares++; $display("[TB] FAIL abort_async: got busy=%b done=%b product=%h expected 0/0/0000", busy, done_flag, product);
    end
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done_flag === 1'b1) pulses++;
    end
    reset_a = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done_flag === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin miscompares++; $display("[TB] FAIL abort_done: got %0d pulses expected 0", pulses); end
    issue_op(8'h37, 8'h59, 1'b0, 1'b1);
    wait_done(cyc, ok);
    exp = exp_q.pop_front();
    vectors++;
    if (cyc != 5 || product !== exp) begin
      miscompares++; $display("[TB] FAIL abort_restart: got lat=%0d product=%h expected 5/%h", cyc, product, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_wide();
    logic [31:0] exp;
    int cyc;
    bit ok;
    a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    exp16_q.push_back({16'h0000, a16} * {16'h0000, b16});
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    ok = 1'b1;
    while (done16 !== 1'b1 && cyc < 60) begin
      if (busy16 !== 1'b1) ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    exp = exp16_q.pop_front();
    vectors++;
    if (cyc != 17 || !ok) begin miscompares++; $display("[TB] FAIL wide_latency: got %0d busy_ok=%b expected 17/1", cyc, ok); end
    vectors++;
    if (product16 !== exp) begin miscompares++; $display("[TB] FAIL wide_product: got %h expected %h", product16, exp); end
    @(negedge clk);
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed();
    logic [7:0] av[4];
    logic [7:0] bv[4];
    logic       sv[4];
    logic [15:0] exp;
    int cyc;
    bit ok;
    av[0] = 8'hFD; bv[0] = 8'h07; sv[0] = 1'b1;
    av[1] = 8'h80; bv[1] = 8'h80; sv[1] = 1'b1;
    av[2] = 8'h80; bv[2] = 8'h01; sv[2] = 1'b1;
    av[3] = 8'hFD; bv[3] = 8'h07; sv[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue_op(av[k], bv[k], sv[k], 1'b1);
      wait_done(cyc, ok);
      exp = exp_q.pop_front();
      vectors++;
      if (cyc != 5 || product !== exp) begin
        miscompares++; $display("[TB] FAIL signed[%0d]: got lat=%0d product=%h expected 5/%h", k, cyc, product, exp);
      end
      @(negedge clk);
    end
    signed_mode = 1'b0;
  endtask
`endif

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    test_wide();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
